tile_line_prefetch: RTL and testbench
=====================================

Name: tile_line_prefetch

Overview:
- Scanline prefetcher that sits directly upstream of the tile renderer.
- On each line-start pulse it walks the 28 tile columns of the requested pixel row.
- For each tile it reads the tile code and colour from video/colour RAM, then the 8-pixel 2bpp row from tile ROM.
- It unpacks the pixels into a ping-pong line buffer, while the renderer reads the previously completed line by column.

Parameters:
- TILE_COLS, 28, tiles per row; buffer width = TILE_COLS*8 = 224 pixels
- TILE_ROWS, 36, tile rows; valid pixel rows 0..TILE_ROWS*8-1 = 0..287
- VRAM_AW, 10, video/colour RAM address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse: swap banks, begin fetching fetch_row
- fetch_row  in  9  pixel row (frame-relative) to prefetch; sampled with line_start
- vram_rd  out  1  read strobe for video RAM and colour RAM
- vram_addr  out  VRAM_AW  tile index = fetch_row[8:3]*TILE_COLS + tile_col
- vram_data  in  8  tile code, valid the cycle after vram_rd
- cram_data  in  6  palette select, valid the cycle after vram_rd
- trom_rd  out  1  tile ROM read strobe
- trom_addr  out  11  {tile_code[7:0], fetch_row[2:0]}
- trom_data  in  16  8 pixels x 2 bits, pixel p in [2p+1:2p]; valid the cycle after trom_rd
- rd_col  in  8  display column 0..223 (frame-relative)
- pix_out  out  8  {palette[5:0], pixel[1:0]} from the read bank; 1-cycle latency
- fetch_busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse when the line is complete
- overrun  out  1  one-cycle pulse: line_start arrived while busy

Behaviour:
- Reset:
  - FSM goes to IDLE; wr_bank=0 (read bank=1); tile_col=0.
  - All outputs 0.
  - Buffer contents are not cleared; they are undefined until first written.
- Storage: two banks of 224 x 8 bits.
  - Write side: write bank only.
  - Read side: pix_out <= rd_bank[rd_col] registered; rd_col>=224 gives pix_out=0.
- line_start (edge E0):
  - wr_bank toggles; read bank is always ~wr_bank.
  - fetch_row is latched and tile_col is cleared.
  - If fetch_row < 288, FSM enters V_REQ; otherwise FSM goes to IDLE with no fetch, no done pulse, bank still swapped.
- FSM states, one cycle each:
  - IDLE.
  - V_REQ: vram_rd=1, vram_addr valid.
  - V_WAIT: capture vram_data/cram_data.
  - T_REQ: trom_rd=1, trom_addr valid.
  - T_WAIT: capture trom_data.
  - WR0..WR7: write entry tile_col*8+p = {palette, pix[p]}.
- After WR7:
  - If tile_col == TILE_COLS-1, go to DONE; else tile_col++ and go to V_REQ.
  - DONE: fetch_done=1 for one cycle, then IDLE.
- Timing:
  - Cycle 0 is the cycle after E0. Each tile takes 12 cycles.
  - fetch_busy=1 in cycles 0..335; fetch_done=1 in cycle 336.
  - Strobes are high only in their request states; addresses hold their values outside those states.
- line_start while busy (including in DONE):
  - overrun=1 that cycle.
  - The current fetch is aborted with no fetch_done, banks swap, and the new fetch restarts at V_REQ.
  - The partially written bank becomes the read bank.
- Simultaneous line_start and rst: rst wins.
- rst mid-fetch: the fetch is abandoned immediately.
- Arithmetic: vram_addr max = 35*28+27 = 1007; computed in VRAM_AW bits with no wrap.

Test Plan:
- Reset then idle: after rst, all outputs 0, fetch_busy=0; read at rd_col=0 gives 0.
- Single fetch:
  - Stimulus: fetch_row=13; model vram_data=tile_col, cram_data=6'h15, trom_data=16'hE4E4.
  - Required: vram_addr sequence 28..55.
  - Required: trom_addr for tile 3 = {8'd3, 3'd5}.
  - Required: fetch_done exactly in cycle 336.
- Readback after swap:
  - Stimulus: after the fetch above, pulse line_start (fetch_row=14), then sweep rd_col 0..7.
  - Required: pix_out = 54,55,56,57 repeating, each with 1-cycle latency; rd_col=224 gives 0.
- Overrun:
  - Stimulus: pulse line_start at cycle 100 of a fetch.
  - Required: overrun pulses once; no fetch_done for the old line; new fetch_done 337 cycles after the second pulse.
- Out-of-range row: line_start with fetch_row=288 gives no vram_rd, no fetch_done, and the bank still swaps.
- Reset mid-fetch: rst at cycle 50 gives busy=0, strobes 0, wr_bank=0 next cycle; a subsequent fetch behaves as in the single-fetch scenario.

Source files
------------

// File: rtl/tile_line_prefetch.sv
// Scanline tile prefetcher: walks one tile row, fetching code/palette and the 2bpp pixel row
// per tile, unpacking into a ping-pong line buffer while the renderer reads the other bank.
module tile_line_prefetch #(
  parameter int TILE_COLS = 28,
  parameter int TILE_ROWS = 36,
  parameter int VRAM_AW   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_start,
  input  logic [8:0]         fetch_row,
  output logic               vram_rd,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_data,
  input  logic [5:0]         cram_data,
  output logic               trom_rd,
  output logic [10:0]        trom_addr,
  input  logic [15:0]        trom_data,
  input  logic [7:0]         rd_col,
  output logic [7:0]         pix_out,
  output logic               fetch_busy,
  output logic               fetch_done,
  output logic               overrun
);
  localparam int LINE_PIX = TILE_COLS * 8;
  localparam int CW = $clog2(TILE_COLS);
  localparam logic [8:0]    ROW_END  = 9'(TILE_ROWS * 8);
  localparam logic [7:0]    COL_END  = 8'(LINE_PIX);
  localparam logic [CW-1:0] LAST_COL = CW'(TILE_COLS - 1);

  typedef enum logic [3:0] {
    IDLE, V_REQ, V_WAIT, T_REQ, T_WAIT,
    WR0, WR1, WR2, WR3, WR4, WR5, WR6, WR7,
    DONE
  } state_t;

  state_t             state;
  logic               wr_bank;
  logic [CW-1:0]      tile_col;
  logic [CW-1:0]      col_next;
  logic [2:0]         row_lo;
  logic [VRAM_AW-1:0] row_base;
  logic [VRAM_AW-1:0] base_new;
  logic [5:0]         pal;
  logic [15:0]        pix_row;
  logic               wr_en;
  logic [2:0]         wr_pix;
  logic [CW+2:0]      wr_addr;
  logic [7:0]         wr_data;
  logic [7:0]         bank0 [LINE_PIX];
  logic [7:0]         bank1 [LINE_PIX];

  always_comb begin
    base_new = VRAM_AW'(fetch_row[8:3]) * VRAM_AW'(TILE_COLS);
    col_next = tile_col + CW'(1);
    wr_en    = (state >= WR0) && (state <= WR7);
    wr_pix   = 3'(state - WR0);
    wr_addr  = {tile_col, wr_pix};
    wr_data  = {pal, pix_row[{wr_pix, 1'b0} +: 2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_bank    <= 1'b0;
      tile_col   <= '0;
      row_lo     <= '0;
      row_base   <= '0;
      pal        <= '0;
      pix_row    <= '0;
      vram_rd    <= 1'b0;
      vram_addr  <= '0;
      trom_rd    <= 1'b0;
      trom_addr  <= '0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vram_rd    <= 1'b0;
      trom_rd    <= 1'b0;
      fetch_done <= 1'b0;
      overrun    <= 1'b0;
      // line_start preempts whatever the walker is doing, DONE included
      if (line_start) begin
        overrun  <= (state != IDLE);
        wr_bank  <= ~wr_bank;
        row_lo   <= fetch_row[2:0];
        tile_col <= '0;
        if (fetch_row < ROW_END) begin
          state      <= V_REQ;
          row_base   <= base_new;
          vram_addr  <= base_new;
          vram_rd    <= 1'b1;
          fetch_busy <= 1'b1;
        end else begin
          state      <= IDLE;
          fetch_busy <= 1'b0;
        end
      end else begin
        case (state)
          IDLE:   state <= IDLE;
          V_REQ:  state <= V_WAIT;
          V_WAIT: begin
            pal       <= cram_data;
            trom_addr <= {vram_data, row_lo};
            trom_rd   <= 1'b1;
            state     <= T_REQ;
          end
          T_REQ:  state <= T_WAIT;
          T_WAIT: begin
            pix_row <= trom_data;
            state   <= WR0;
          end
          WR0, WR1, WR2, WR3, WR4, WR5, WR6: state <= state_t'(state + 4'd1);
          WR7: begin
            if (tile_col == LAST_COL) begin
              state      <= DONE;
              fetch_busy <= 1'b0;
              fetch_done <= 1'b1;
            end else begin
              tile_col  <= col_next;
              vram_addr <= row_base + VRAM_AW'(col_next);
              vram_rd   <= 1'b1;
              state     <= V_REQ;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) bank1[wr_addr] <= wr_data;
      else         bank0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out <= '0;
    end else if (rd_col < COL_END) begin
      pix_out <= wr_bank ? bank0[rd_col] : bank1[rd_col];
    end else begin
      pix_out <= '0;
    end
  end
endmodule

// File: tb/tb_tile_line_prefetch.sv
// Bench for tile_line_prefetch: memory model, expectation queues checked on strobes,
// table-driven line buffer readback and hand-written overrun/reset sequences.
module tb_tile_line_prefetch;
  logic        clk = 1'b0;
  logic        rst, line_start;
  logic [8:0]  fetch_row;
  logic        vram_rd;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [5:0]  cram_data = 6'h15;
  logic        trom_rd;
  logic [10:0] trom_addr;
  logic [15:0] trom_data;
  logic [7:0]  rd_col, pix_out;
  logic        fetch_busy, fetch_done, overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [15:0] trom_pat = 16'hE4E4;

  typedef struct { int cyc; logic [7:0] exp; } pend_t;
  typedef struct { logic [7:0] col; logic [7:0] exp_a; logic [7:0] exp_b; } rb_vec_t;

  int    vq[$], tq[$], dq[$], oq[$];
  pend_t pq[$];
  rb_vec_t rb[12];

  tile_line_prefetch #(.TILE_COLS(28), .TILE_ROWS(36), .VRAM_AW(10)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .fetch_row(fetch_row),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data), .cram_data(cram_data),
    .trom_rd(trom_rd), .trom_addr(trom_addr), .trom_data(trom_data),
    .rd_col(rd_col), .pix_out(pix_out), .fetch_busy(fetch_busy),
    .fetch_done(fetch_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM/ROM model: code = column within the row, fixed palette, selectable pixel pattern
  always @(posedge clk) begin
    if (vram_rd) vram_data <= 8'(vram_addr % 10'd28);
    if (trom_rd) trom_data <= trom_pat;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (vram_rd === 1'b1) begin
      if (vq.size() == 0) check("vram_rd_unexpected", 32'(vram_rd), 0);
      else check("vram_addr", 32'(vram_addr), vq.pop_front());
    end
    if (trom_rd === 1'b1) begin
      if (tq.size() == 0) check("trom_rd_unexpected", 32'(trom_rd), 0);
      else check("trom_addr", 32'(trom_addr), tq.pop_front());
    end
    if (fetch_done === 1'b1) begin
      if (dq.size() == 0) check("done_unexpected", 32'(fetch_done), 0);
      else check("done_cycle", cyc, dq.pop_front());
    end
    if (overrun === 1'b1) begin
      if (oq.size() == 0) check("overrun_unexpected", 32'(overrun), 0);
      else check("overrun_cycle", cyc, oq.pop_front());
    end
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      pend_t p;
      p = pq.pop_front();
      check("pix_out", 32'(pix_out), 32'(p.exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic flush();
    vq.delete(); tq.delete(); dq.delete(); oq.delete();
  endtask

  task automatic start_line(input logic [8:0] row, output int t0);
    int base;
    line_start = 1'b1;
    fetch_row  = row;
    t0 = cyc + 1;
    if (int'(row) < 288) begin
      base = (int'(row) >> 3) * 28;
      for (int c = 0; c < 28; c++) begin
        vq.push_back(base + c);
        tq.push_back(int'({c[7:0], row[2:0]}));
      end
      dq.push_back(t0 + 336);
    end
    tick();
    line_start = 1'b0;
  endtask

  task automatic expect_pix(input logic [7:0] col, input logic [7:0] exp);
    pend_t p;
    rd_col = col;
    p.cyc = cyc + 1;
    p.exp = exp;
    pq.push_back(p);
    tick();
  endtask

  task automatic readback(input bit second);
    for (int i = 0; i < 12; i++) expect_pix(rb[i].col, second ? rb[i].exp_b : rb[i].exp_a);
    tick();
  endtask

  task automatic drained(input string name);
    check({name, "_vq"}, vq.size(), 0);
    check({name, "_tq"}, tq.size(), 0);
    check({name, "_dq"}, dq.size(), 0);
    check({name, "_oq"}, oq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2;
    // pattern a = 16'hE4E4 (pixels 0,1,2,3), b = 16'h1B1B (pixels 3,2,1,0); palette 6'h15
    rb[0]  = '{8'd0,   8'h54, 8'h57};
    rb[1]  = '{8'd1,   8'h55, 8'h56};
    rb[2]  = '{8'd2,   8'h56, 8'h55};
    rb[3]  = '{8'd3,   8'h57, 8'h54};
    rb[4]  = '{8'd4,   8'h54, 8'h57};
    rb[5]  = '{8'd5,   8'h55, 8'h56};
    rb[6]  = '{8'd6,   8'h56, 8'h55};
    rb[7]  = '{8'd7,   8'h57, 8'h54};
    rb[8]  = '{8'd100, 8'h54, 8'h57};
    rb[9]  = '{8'd223, 8'h57, 8'h54};
    rb[10] = '{8'd224, 8'h00, 8'h00};
    rb[11] = '{8'd255, 8'h00, 8'h00};

    rst = 1'b1; line_start = 1'b0; fetch_row = '0; rd_col = 8'd224;
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_vram_rd", 32'(vram_rd), 0);
    check("rst_vram_addr", 32'(vram_addr), 0);
    check("rst_trom_rd", 32'(trom_rd), 0);
    check("rst_trom_addr", 32'(trom_addr), 0);
    check("rst_busy", 32'(fetch_busy), 0);
    check("rst_done", 32'(fetch_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_pix_out", 32'(pix_out), 0);
    tick(); rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("idle_busy", 32'(fetch_busy), 0);
    check("idle_pix_out", 32'(pix_out), 0);

    // single fetch of row 13 into bank 1
    tick();
    start_line(9'd13, t0);
    to_cycle(t0);
    check("busy_first", 32'(fetch_busy), 1);
    to_cycle(t0 + 38);
    check("tile3_trom_rd", 32'(trom_rd), 1);
    check("tile3_trom_addr", 32'(trom_addr), 32'({8'd3, 3'd5}));
    to_cycle(t0 + 335);
    check("busy_last", 32'(fetch_busy), 1);
    check("done_early", 32'(fetch_done), 0);
    to_cycle(t0 + 336);
    check("busy_at_done", 32'(fetch_busy), 0);
    check("done_at_336", 32'(fetch_done), 1);
    to_cycle(t0 + 337);
    check("done_width", 32'(fetch_done), 0);
    drained("single");

    // swap: row 13 readable while row 14 is fetched with the other pattern
    tick();
    trom_pat = 16'h1B1B;
    start_line(9'd14, t1);
    readback(1'b0);
    to_cycle(t1 + 337);
    drained("row14");

    // out-of-range row: no fetch, but banks still swap
    tick();
    start_line(9'd288, t2);
    readback(1'b1);
    @(negedge clk);
    check("oor_busy", 32'(fetch_busy), 0);
    drained("oor");

    // overrun at cycle 100 of a fetch
    tick();
    trom_pat = 16'hE4E4;
    start_line(9'd13, t0);
    to_cycle(t0 + 99);
    tick();
    check("ovr_vram_left", vq.size(), 19);
    check("ovr_trom_left", tq.size(), 19);
    flush();
    oq.push_back(cyc + 1);
    dq.push_back(cyc + 337);
    start_line(9'd21, t1);
    void'(dq.pop_back());
    to_cycle(t1 + 337);
    drained("overrun");
    // aborted bank: early tiles rewritten, later tiles keep the previous line
    tick();
    expect_pix(8'd3, 8'h57);
    expect_pix(8'd100, 8'h57);
    expect_pix(8'd200, 8'h57);
    tick();

    // reset mid-fetch with wr_bank=1, then a clean fetch
    start_line(9'd288, t2);
    start_line(9'd13, t0);
    to_cycle(t0 + 49);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush();
    @(negedge clk);
    check("rstmid_busy", 32'(fetch_busy), 0);
    check("rstmid_vram_rd", 32'(vram_rd), 0);
    check("rstmid_trom_rd", 32'(trom_rd), 0);
    check("rstmid_done", 32'(fetch_done), 0);
    tick();
    start_line(9'd13, t0);
    to_cycle(t0 + 336);
    check("post_rst_done", 32'(fetch_done), 1);
    to_cycle(t0 + 337);
    drained("post_rst");
    tick();
    start_line(9'd288, t2);
    readback(1'b0);
    drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
